// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter multiplexing N_REQ requesters onto one memory unit
// Each requester owns a one-deep capture slot; the FSM issues one access at a time and waits for mem_ready or timeout.
module mem_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_execute,
  input  logic [2*N_REQ-1:0]       req_func,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr1,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr2,
  input  logic [DATA_W*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]        req_rdata1,
  output logic [DATA_W-1:0]        req_rdata2,
  output logic                     mem_execute,
  output logic [1:0]               mem_func,
  output logic [ADDR_W-1:0]        address1,
  output logic [ADDR_W-1:0]        address2,
  output logic [DATA_W-1:0]        write_data,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        read_data1,
  input  logic [DATA_W-1:0]        read_data2,
  output logic                     busy,
  output logic [1:0]               grant_id,
  output logic [N_REQ-1:0]         overrun_err,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_next;
  logic [N_REQ-1:0]    pend;
  logic [1:0]          slot_func  [N_REQ];
  logic [ADDR_W-1:0]   slot_addr1 [N_REQ];
  logic [ADDR_W-1:0]   slot_addr2 [N_REQ];
  logic [DATA_W-1:0]   slot_wdata [N_REQ];
  logic [1:0]          last_grant;
  logic [7:0]          wait_cnt;
  logic                pick_valid;
  logic [1:0]          pick;
  logic                done;
  logic                timed_out;

  // Scan downwards so the last hit is the requester closest after last_grant.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (pend[(int'(last_grant) + k) % N_REQ]) begin
        pick_valid = 1'b1;
        pick       = 2'((int'(last_grant) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE:  if (pick_valid) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (mem_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          done       = 1'b1;
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_execute = (state == ISSUE);
  assign mem_func    = (state == ISSUE) ? slot_func[grant_id] : 2'b00;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= '0;
      last_grant  <= 2'(N_REQ - 1);
      grant_id    <= '0;
      wait_cnt    <= '0;
      address1    <= '0;
      address2    <= '0;
      write_data  <= '0;
      req_ready   <= '0;
      req_rdata1  <= '0;
      req_rdata2  <= '0;
      overrun_err <= '0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= '0;

      if (state == IDLE && pick_valid) begin
        grant_id   <= pick;
        address1   <= slot_addr1[pick];
        address2   <= slot_addr2[pick];
        write_data <= slot_wdata[pick];
      end

      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;

      if (done) begin
        req_ready[grant_id] <= 1'b1;
        req_rdata1          <= timed_out ? '0 : read_data1;
        req_rdata2          <= timed_out ? '0 : read_data2;
        last_grant          <= grant_id;
        if (timed_out) timeout_err <= 1'b1;
      end

      // A completing slot is free again at this same edge, so a fresh pulse is accepted.
      for (int i = 0; i < N_REQ; i++) begin
        if (req_execute[i]) begin
          if (pend[i] && !(done && grant_id == 2'(i))) begin
            overrun_err[i] <= 1'b1;
          end else begin
            pend[i]       <= 1'b1;
            slot_func[i]  <= req_func[2*i +: 2];
            slot_addr1[i] <= req_addr1[ADDR_W*i +: ADDR_W];
            slot_addr2[i] <= req_addr2[ADDR_W*i +: ADDR_W];
            slot_wdata[i] <= req_wdata[DATA_W*i +: DATA_W];
          end
        end else if (done && grant_id == 2'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule
